// File: rtl/fetch_predict.sv
// Instruction fetch stage with a direct-mapped branch target buffer and
// 2-bit saturating direction counters. The PC register is steered by
// mispredict redirects from execute, stall/halt holds, and the local
// prediction for the current fetch.
module fetch_predict #(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic [15:0] imem_instr,
  input  logic        imem_stall,
  input  logic        imem_err,
  input  logic        ex_valid,
  input  logic [15:0] ex_pc,
  input  logic        ex_taken,
  input  logic [15:0] ex_target,
  input  logic        ex_predicted,
  output logic [15:0] imem_addr,
  output logic [15:0] IF_instr,
  output logic [15:0] IF_PC_Next,
  output logic        IF_expectedTaken,
  output logic        IF_err,
  output logic        fetch_stall,
  output logic        NOP_Branch
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned TAG_W = 16 - IDX_W - 1;

  // Architectural state
  logic [15:0]      pc_q;
  logic [15:0]      pc_d;
  logic             valid_q [BHT_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BHT_ENTRIES];
  logic [15:0]      tgt_q   [BHT_ENTRIES];
  logic [1:0]       cnt_q   [BHT_ENTRIES];

  // Lookup side (current fetch)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [15:0]      pc_plus2;
  logic [15:0]      pred_next;

  // Update side (resolving branch)
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_alias;
  logic [1:0]       cnt_d;
  logic             mispredict;
  logic [15:0]      redirect_pc;

  assign lk_idx   = pc_q[IDX_W:1];
  assign lk_tag   = pc_q[15:IDX_W+1];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pc_plus2 = pc_q + 16'd2;

  assign up_idx   = ex_pc[IDX_W:1];
  assign up_tag   = ex_pc[15:IDX_W+1];
  assign up_alias = valid_q[up_idx] && (tag_q[up_idx] != up_tag);

  // Flush is suppressed while reset is held so the IF/ID stage sees a clean start
  assign mispredict  = rst && ex_valid && (ex_taken != ex_predicted);
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + 16'd2);

  // Prediction for the current fetch, taken from pre-update table contents
  always_comb begin
    IF_expectedTaken = lk_hit && cnt_q[lk_idx][1];
    pred_next        = IF_expectedTaken ? tgt_q[lk_idx] : pc_plus2;
  end

  // PC next-state: redirect beats halt, halt/stall hold beats prediction
  always_comb begin
    pc_d = pred_next;
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (halt || stall || imem_stall) begin
      pc_d = pc_q;
    end
  end

  // Counter next value for the resolving branch's entry
  always_comb begin
    cnt_d = cnt_q[up_idx];
    if (ex_taken) begin
      if (up_alias) begin
        cnt_d = 2'b10;
      end else if (cnt_q[up_idx] != 2'b11) begin
        cnt_d = cnt_q[up_idx] + 2'd1;
      end
    end else if (cnt_q[up_idx] != 2'b00) begin
      cnt_d = cnt_q[up_idx] - 2'd1;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Valid bits and direction counters; reset clears any in-flight update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (ex_valid) begin
      cnt_q[up_idx] <= cnt_d;
      if (ex_taken) begin
        valid_q[up_idx] <= 1'b1;
      end
    end
  end

  // Tags and targets carry no reset; they are qualified by the valid bit
  always_ff @(posedge clk) begin
    if (rst && ex_valid && ex_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= ex_target;
    end
  end

  assign imem_addr   = pc_q;
  assign IF_PC_Next  = pc_plus2;
  assign IF_instr    = imem_instr;
  assign IF_err      = imem_err;
  assign fetch_stall = imem_stall;
  assign NOP_Branch  = mispredict;

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 Parameter BHT_ENTRIES, 16, number of direct-mapped predictor entries; power of two, indexed by PC[log2(BHT_ENTRIES):1].
REQ-002 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 stall  in  1  hazard-unit hold; PC frozen while high.
REQ-006 halt  in  1  halt decoded downstream; PC frozen while high.
REQ-007 imem_instr  in  16  instruction word read at imem_addr.
REQ-008 imem_stall  in  1  instruction memory not ready this cycle.
REQ-009 imem_err  in  1  instruction memory fault on current fetch.
REQ-010 ex_valid  in  1  execute stage resolving a conditional branch this cycle.
REQ-011 ex_pc  in  16  PC of the resolving branch.
REQ-012 ex_taken  in  1  actual branch outcome.
REQ-013 ex_target  in  16  actual taken target.
REQ-014 ex_predicted  in  1  prediction carried down the pipe with that branch.
REQ-015 imem_addr  out  16  current PC.
REQ-016 IF_instr  out  16  equals imem_instr.
REQ-017 IF_PC_Next  out  16  imem_addr + 2, modulo 2^16.
REQ-018 IF_expectedTaken  out  1  prediction for the current fetch.
REQ-019 IF_err  out  1  equals imem_err.
REQ-020 fetch_stall  out  1  equals imem_stall.
REQ-021 NOP_Branch  out  1  mispredict flush to IF/ID stage.

Function
REQ-022 State: 16-bit PC register; per entry a valid bit, tag = PC[15:log2(BHT_ENTRIES)+1], 16-bit target, and a 2-bit saturating counter.
REQ-023 Lookup is combinational on the current PC; hit = valid and tag match.
REQ-024 IF_expectedTaken = hit and counter[1].
REQ-025 Predicted next PC = stored target when IF_expectedTaken is high; otherwise IF_PC_Next.
REQ-026 Mispredict = ex_valid and (ex_taken != ex_predicted); NOP_Branch = mispredict, combinational in the same cycle.
REQ-027 Redirect PC = ex_target when ex_taken is high; otherwise ex_pc + 2.
REQ-028 PC next-state priority, highest first: reset; mispredict redirect; halt hold; stall or imem_stall hold; predicted next PC.
REQ-029 A mispredict overrides stall, halt and imem_stall.
REQ-030 On ex_valid, the counter at ex_pc's index updates: increment saturating at 11 when taken, decrement saturating at 00 when not taken.
REQ-031 On ex_valid with ex_taken high, the entry at ex_pc's index is written with valid=1, ex_pc's tag and ex_target.
REQ-032 If ex_pc's tag differs from a valid entry's tag, the entry is replaced and its counter is set to 10, not incremented.
REQ-033 Not-taken resolutions never write tag, target or valid.
REQ-034 When an update and a lookup hit the same index in the same cycle, the lookup sees pre-update contents; the write takes effect at the edge.
REQ-035 Outputs IF_instr, IF_err and fetch_stall pass through unregistered; IF/ID handles NOP insertion.

Reset
REQ-036 rst low asynchronously sets PC=RESET_PC, all valid bits=0, all counters=01; tags and targets are don't-care.
REQ-037 During and immediately after reset: imem_addr=RESET_PC, IF_PC_Next=RESET_PC+2, IF_expectedTaken=0, NOP_Branch=0.
REQ-038 Reset asserted mid-update discards that update.
REQ-039 Deassertion takes effect on the first rising edge after rst goes high.

Verification
REQ-040 Scenario: reset, no stalls, 4 cycles -> imem_addr 0000, 0002, 0004, 0006; IF_expectedTaken=0 throughout.
REQ-041 Scenario: resolve branch ex_pc=0006, taken, target 0020, ex_predicted=0 -> NOP_Branch=1 that cycle; next PC=0020; entry valid; counter 10.
REQ-042 Scenario: after REQ-041, fetch reaches 0006 again -> IF_expectedTaken=1; next PC=0020.
REQ-043 Scenario: two not-taken resolutions of 0006 with ex_predicted=1 then 0 -> first flushes to 0008; counter reaches 00; later fetch of 0006 predicts not taken; counter does not wrap below 00.
REQ-044 Scenario: stall=1 and imem_stall=1 with PC=0010 for 3 cycles -> PC holds 0010; mispredict during the stall redirects anyway.
REQ-045 Scenario: aliasing branch at 0026 (same index as 0006, different tag) taken to 0040 -> entry replaced; fetch at 0006 misses; IF_expectedTaken=0.
